// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares one single-port unified memory between instruction fetch (IF) and
// data load/store (D). Each access runs IDLE -> ACCESS -> DONE. The ACCESS
// phase lasts MEM_LAT cycles. Read data is returned with a one-cycle done
// pulse to the requester that owns the access.
//
// Optional build macro: ARB_RR_EN
//   defined   : round-robin arbitration. The pointer flips to the other
//               requester after every grant, and the pointed-to side wins
//               a tie. After reset the pointer selects D.
//   undefined : fixed priority, D over IF. No pointer register is built.
//
// State table
//   state     | meaning
//   ST_IDLE   | sample requests, grant one, latch its address/we/wdata
//   ST_ACCESS | drive memory for MEM_LAT cycles, capture read data on last
//   ST_DONE   | pulse owner's done for one cycle, memory idle

module mem_access_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             owner_d_q;
  logic             req_any;
  logic             grant_d;
  logic             take;
  logic             last_beat;

  assign req_any   = if_req | d_req;
  assign take      = (state_q == ST_IDLE) && req_any;
  assign last_beat = (state_q == ST_ACCESS) && (cnt_q == '0);

`ifdef ARB_RR_EN
  logic rr_d_q;

  // D wins if it is the only requester, or on a tie when the pointer favours D
  assign grant_d = d_req & (~if_req | rr_d_q);

  // Pointer moves to the side that was not just granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_d_q <= 1'b1;
    end else if (take) begin
      rr_d_q <= ~grant_d;
    end
  end
`else
  // Fixed priority: any D request beats IF
  assign grant_d = d_req;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status/done outputs
  always_comb begin
    state_d = state_q;
    if_done = 1'b0;
    d_done  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        if_done = ~owner_d_q;
        d_done  = owner_d_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the granted request and drive the memory from registers only.
  // This keeps mem_* glitch-free and unaffected by requester changes mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      owner_d_q <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (take) begin
      cnt_q     <= CNT_INIT;
      owner_d_q <= grant_d;
      mem_en    <= 1'b1;
      mem_we    <= grant_d & d_we;
      mem_addr  <= grant_d ? d_addr : if_addr;
      mem_wdata <= grant_d ? d_wdata : '0;
    end else if (state_q == ST_ACCESS) begin
      if (cnt_q == '0) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Capture read data on the final access cycle into the owner's register.
  // A store leaves d_rdata holding the last load value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (last_beat) begin
      if (!owner_d_q) begin
        if_rdata <= mem_rdata;
      end else if (!mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter. Instance 0 uses MEM_LAT=2 and is checked
// through a scoreboard of expected done events. Instances 1 and 2 use
// MEM_LAT=1 and MEM_LAT=4 and are used to check latency scaling.
module tb_mem_access_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NI = 3;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  typedef struct {
    bit            is_d;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  logic          if_req   [NI];
  logic [AW-1:0] if_addr  [NI];
  logic [DW-1:0] if_rdata [NI];
  logic          if_done  [NI];
  logic          d_req    [NI];
  logic          d_we     [NI];
  logic [AW-1:0] d_addr   [NI];
  logic [DW-1:0] d_wdata  [NI];
  logic [DW-1:0] d_rdata  [NI];
  logic          d_done   [NI];
  logic          mem_en   [NI];
  logic          mem_we   [NI];
  logic [AW-1:0] mem_addr [NI];
  logic [DW-1:0] mem_wdata[NI];
  logic          busy     [NI];

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            we_cyc = 0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_wdata = '0;
  logic [DW-1:0] last_d = '0;
  bit            pend    [NI];
  int            exp_cyc [NI];
  logic [DW-1:0] exp_dat [NI];
  logic [AW-1:0] exp_addr[NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] rdm;
    int            en_n;

    // memory model: data is valid only on the last cycle of a MEM_LAT-long access
    always @(posedge clk or negedge rst_n)
      if (!rst_n) en_n <= 0;
      else        en_n <= mem_en[g] ? en_n + 1 : 0;

    assign rdm = (mem_en[g] && en_n == lat_of(g) - 1) ? model_data(mem_addr[g])
                                                      : 32'hBAD0_BAD0;

    mem_access_arbiter #(.MEM_LAT(lat_of(g)), .ADDR_W(AW), .DATA_W(DW)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_rdata (if_rdata[g]),
      .if_done  (if_done[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_rdata  (d_rdata[g]),
      .d_done   (d_done[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(rdm),
      .busy     (busy[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_d, input logic [DW-1:0] data, input int c);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit outstanding();
    return if_req[0] || d_req[0] || if_req[1] || if_req[2] ||
           (sb.size() != 0) || pend[1] || pend[2];
  endfunction

  // requester behaviour: drop req in the cycle after its done pulse
  task automatic service(input int budget);
    int n;
    bit di0, dd0, di1, di2;
    n = 0;
    while (outstanding() && n < budget) begin
      @(negedge clk);
      di0 = if_done[0];
      dd0 = d_done[0];
      di1 = if_done[1];
      di2 = if_done[2];
      @(posedge clk);
      #1;
      if (di0) if_req[0] = 1'b0;
      if (dd0) d_req[0]  = 1'b0;
      if (di1) if_req[1] = 1'b0;
      if (di2) if_req[2] = 1'b0;
      n++;
    end
    checks++;
    if (outstanding()) begin
      errors++;
      $display("FAIL service_timeout: got work outstanding after %0d cycles expected none", budget);
    end
  endtask

  // monitor: pops the scoreboard on every done pulse
  initial begin : mon
    exp_t          e;
    logic [DW-1:0] act_data;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_en[0])
          chk("mem_en_only_in_access", 64'(busy[0] & ~if_done[0] & ~d_done[0]), 64'd1);
        if (mem_en[0] && mem_we[0]) begin
          we_cyc++;
          chk("store_mem_addr", 64'(mem_addr[0]), 64'(st_addr));
          chk("store_mem_wdata", 64'(mem_wdata[0]), 64'(st_wdata));
        end
        if (if_done[0] || d_done[0]) begin
          chk("single_done", 64'(if_done[0] & d_done[0]), 64'd0);
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            act_data = d_done[0] ? d_rdata[0] : if_rdata[0];
            if ((d_done[0] != e.is_d) || (act_data !== e.data) || (cyc != e.cyc)) begin
              errors++;
              $display("FAIL sb_done: got d=%0b data=%h cyc=%0d expected d=%0b data=%h cyc=%0d",
                       d_done[0], act_data, cyc, e.is_d, e.data, e.cyc);
            end
          end
        end
        for (int k = 1; k < NI; k++) begin
          if (mem_en[k])
            chk("lat_mem_addr_latched", 64'(mem_addr[k]), 64'(exp_addr[k]));
          if (if_done[k]) begin
            checks++;
            if (!pend[k] || (if_rdata[k] !== exp_dat[k]) || (cyc != exp_cyc[k])) begin
              errors++;
              $display("FAIL lat%0d_done: got data=%h cyc=%0d expected data=%h cyc=%0d",
                       lat_of(k), if_rdata[k], cyc, exp_dat[k], exp_cyc[k]);
            end
            pend[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  t;
    int  l0;
    int  nd;
    int  n;
    bit  isd;
    l0 = lat_of(0);
    for (int k = 0; k < NI; k++) begin
      if_req[k]  = 1'b0;
      if_addr[k] = '0;
      d_req[k]   = 1'b0;
      d_we[k]    = 1'b0;
      d_addr[k]  = '0;
      d_wdata[k] = '0;
      pend[k]    = 1'b0;
      exp_cyc[k] = 0;
      exp_dat[k] = '0;
      exp_addr[k] = '0;
    end

    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_mem_en",    64'(mem_en[0]),    64'd0);
    chk("rst_mem_we",    64'(mem_we[0]),    64'd0);
    chk("rst_mem_addr",  64'(mem_addr[0]),  64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata[0]), 64'd0);
    chk("rst_busy",      64'(busy[0]),      64'd0);
    chk("rst_if_done",   64'(if_done[0]),   64'd0);
    chk("rst_d_done",    64'(d_done[0]),    64'd0);
    chk("rst_if_rdata",  64'(if_rdata[0]),  64'd0);
    chk("rst_d_rdata",   64'(d_rdata[0]),   64'd0);
    @(negedge clk) rst_n = 1'b1;

    // single fetch
    tick();
    if_addr[0] = 32'h100;
    if_req[0]  = 1'b1;
    push(1'b0, 32'hDEAD_BEEF, cyc + 1 + l0);
    service(30);

    // simultaneous fetch and load: D first, IF after an idle cycle
    tick();
    t = cyc;
    if_addr[0] = 32'h80;
    d_addr[0]  = 32'h200;
    d_we[0]    = 1'b0;
    if_req[0]  = 1'b1;
    d_req[0]   = 1'b1;
    push(1'b1, model_data(32'h200), t + 1 + l0);
    push(1'b0, model_data(32'h80),  t + 2 * l0 + 3);
    last_d = model_data(32'h200);
    service(40);

    // store: two write cycles, d_rdata keeps last load value
    st_addr  = 32'h40;
    st_wdata = 32'h1234_5678;
    we_cyc   = 0;
    tick();
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h40;
    d_wdata[0] = 32'h1234_5678;
    d_req[0]   = 1'b1;
    push(1'b1, last_d, cyc + 1 + l0);
    service(30);
    chk("store_we_cycles", 64'(we_cyc), 64'(l0));
    d_we[0] = 1'b0;

    // load dropped and re-addressed mid-access still completes on latched address
    tick();
    d_addr[0] = 32'h208;
    d_req[0]  = 1'b1;
    push(1'b1, model_data(32'h208), cyc + 1 + l0);
    last_d = model_data(32'h208);
    tick();
    d_req[0]  = 1'b0;
    d_addr[0] = 32'hAAAA_0000;
    service(30);

    // both held continuously from a fresh reset
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    t = cyc;
    if_addr[0] = 32'h104;
    d_addr[0]  = 32'h300;
    if_req[0]  = 1'b1;
    d_req[0]   = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      isd = (i % 2 == 0);
`else
      isd = 1'b1;
`endif
      push(isd, isd ? model_data(32'h300) : model_data(32'h104), t + 1 + l0 + i * (l0 + 2));
    end
    nd = 0;
    n  = 0;
    while (nd < 4 && n < 60) begin
      @(negedge clk);
      if (if_done[0] || d_done[0]) nd++;
      n++;
    end
    @(posedge clk);
    #1;
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    chk("held_grant_count", 64'(nd), 64'd4);
    service(30);

    // reset during a store access aborts immediately
    st_addr  = 32'h44;
    st_wdata = 32'hCAFE_F00D;
    tick();
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h44;
    d_wdata[0] = 32'hCAFE_F00D;
    d_req[0]   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_mem_en_before", 64'(mem_en[0]), 64'd1);
    #1;
    rst_n    = 1'b0;
    d_req[0] = 1'b0;
    d_we[0]  = 1'b0;
    #1;
    chk("abort_mem_en", 64'(mem_en[0]), 64'd0);
    chk("abort_mem_we", 64'(mem_we[0]), 64'd0);
    chk("abort_busy",   64'(busy[0]),   64'd0);
    chk("abort_d_done", 64'(d_done[0]), 64'd0);
    tick();
    tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    if_addr[0] = 32'h600;
    if_req[0]  = 1'b1;
    push(1'b0, model_data(32'h600), cyc + 1 + l0);
    service(30);

    // MEM_LAT=1 and MEM_LAT=4 instances, fetch address changed mid-access
    tick();
    for (int k = 1; k < NI; k++) begin
      if_addr[k]  = 32'h6FC + 32'(4 * k);
      exp_addr[k] = 32'h6FC + 32'(4 * k);
      exp_dat[k]  = model_data(32'h6FC + 32'(4 * k));
      exp_cyc[k]  = cyc + 1 + lat_of(k);
      pend[k]     = 1'b1;
      if_req[k]   = 1'b1;
    end
    tick();
    if_addr[1] = 32'hFFF4;
    if_addr[2] = 32'hFFF0;
    service(40);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
